// File: rtl/pc_sequencer_if.sv
// rtl/pc_sequencer_if.sv - redirect request / fetch address bundle for the PC sequencer
interface pc_sequencer_if #(
  parameter int PC_WIDTH = 32
);
  logic                stall;
  logic                branch_taken;
  logic [PC_WIDTH-1:0] branch_target;
  logic                jump_valid;
  logic [PC_WIDTH-1:0] jump_target;
  logic                trap_valid;
  logic [PC_WIDTH-1:0] trap_target;
  logic [PC_WIDTH-1:0] pc;
  logic [PC_WIDTH-1:0] pc_plus_4;
  logic                redirect_pending;
  logic                misalign_err;
  logic [PC_WIDTH-1:0] misalign_addr;

  // Requesting side: pipeline control, branch/jump resolution, trap unit.
  modport master (
    output stall, branch_taken, branch_target, jump_valid, jump_target,
           trap_valid, trap_target,
    input  pc, pc_plus_4, redirect_pending, misalign_err, misalign_addr
  );

  // Sequencer side.
  modport slave (
    input  stall, branch_taken, branch_target, jump_valid, jump_target,
           trap_valid, trap_target,
    output pc, pc_plus_4, redirect_pending, misalign_err, misalign_addr
  );
endinterface

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - program counter with prioritised redirects, stall latch and alignment check
module pc_sequencer #(
  parameter int                     PC_WIDTH     = 32,
  parameter logic [PC_WIDTH-1:0]    RESET_VECTOR = '0,
  parameter int                     ALIGN_BITS   = 2
) (
  input  logic          clk_i,
  input  logic          rst_i,
  pc_sequencer_if.slave bus
);

  // Priority classes; numeric order is the arbitration order.
  typedef enum logic [1:0] {
    CLS_NONE   = 2'd0,
    CLS_BRANCH = 2'd1,
    CLS_JUMP   = 2'd2,
    CLS_TRAP   = 2'd3
  } cls_e;

  localparam logic [PC_WIDTH-1:0] ALIGN_MASK = (PC_WIDTH'(1) << ALIGN_BITS) - PC_WIDTH'(1);

  logic [PC_WIDTH-1:0] pc_q, pc_d;
  cls_e                pend_cls_q, pend_cls_d;
  logic [PC_WIDTH-1:0] pend_tgt_q, pend_tgt_d;
  logic                merr_q, merr_d;
  logic [PC_WIDTH-1:0] maddr_q, maddr_d;

  logic                jump_mis, branch_mis;
  cls_e                new_cls, eff_cls;
  logic [PC_WIDTH-1:0] new_tgt, eff_tgt;
  logic                take_pend;

  // Arbitrate new requests, merge with the pending latch and form next state.
  always_comb begin
    jump_mis   = bus.jump_valid   && ((bus.jump_target   & ALIGN_MASK) != '0);
    branch_mis = bus.branch_taken && ((bus.branch_target & ALIGN_MASK) != '0);

    // Misaligned branch/jump requests are dropped so a lower-priority one can win.
    new_cls = CLS_NONE;
    new_tgt = '0;
    if (bus.trap_valid) begin
      new_cls = CLS_TRAP;
      new_tgt = bus.trap_target & ~ALIGN_MASK;
    end else if (bus.jump_valid && !jump_mis) begin
      new_cls = CLS_JUMP;
      new_tgt = bus.jump_target;
    end else if (bus.branch_taken && !branch_mis) begin
      new_cls = CLS_BRANCH;
      new_tgt = bus.branch_target;
    end

    // Report the highest-priority branch/jump request if it was misaligned.
    merr_d  = 1'b0;
    maddr_d = maddr_q;
    if (jump_mis) begin
      merr_d  = 1'b1;
      maddr_d = bus.jump_target;
    end else if (branch_mis && !bus.jump_valid) begin
      merr_d  = 1'b1;
      maddr_d = bus.branch_target;
    end

    take_pend = (pend_cls_q != CLS_NONE) && ((new_cls == CLS_NONE) || (pend_cls_q >= new_cls));
    eff_cls   = take_pend ? pend_cls_q : new_cls;
    eff_tgt   = take_pend ? pend_tgt_q : new_tgt;

    pc_d       = pc_q;
    pend_cls_d = pend_cls_q;
    pend_tgt_d = pend_tgt_q;
    if (!bus.stall) begin
      pc_d       = (eff_cls != CLS_NONE) ? eff_tgt : (pc_q + PC_WIDTH'(4));
      pend_cls_d = CLS_NONE;
    end else if ((new_cls != CLS_NONE) &&
                 ((pend_cls_q == CLS_NONE) || (new_cls >= pend_cls_q))) begin
      pend_cls_d = new_cls;
      pend_tgt_d = new_tgt;
    end
  end

  // State registers; reset discards any latched redirect.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_q       <= RESET_VECTOR;
      pend_cls_q <= CLS_NONE;
      pend_tgt_q <= '0;
      merr_q     <= 1'b0;
      maddr_q    <= '0;
    end else begin
      pc_q       <= pc_d;
      pend_cls_q <= pend_cls_d;
      pend_tgt_q <= pend_tgt_d;
      merr_q     <= merr_d;
      maddr_q    <= maddr_d;
    end
  end

  assign bus.pc               = pc_q;
  assign bus.pc_plus_4        = pc_q + PC_WIDTH'(4);
  assign bus.redirect_pending = (pend_cls_q != CLS_NONE);
  assign bus.misalign_err     = merr_q;
  assign bus.misalign_addr    = maddr_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - table-driven check of pc_sequencer
module tb_pc_sequencer;

  logic clk;
  logic rst;
  logic rst1;

  pc_sequencer_if #(.PC_WIDTH(32)) bus0 ();
  pc_sequencer_if #(.PC_WIDTH(32)) bus1 ();

  pc_sequencer #(.PC_WIDTH(32), .RESET_VECTOR(32'h0), .ALIGN_BITS(2)) dut0 (
    .clk_i(clk), .rst_i(rst), .bus(bus0.slave)
  );

  pc_sequencer #(.PC_WIDTH(32), .RESET_VECTOR(32'h0000_1000), .ALIGN_BITS(1)) dut1 (
    .clk_i(clk), .rst_i(rst1), .bus(bus1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        stall;
    logic        bv;
    logic [31:0] bt;
    logic        jv;
    logic [31:0] jt;
    logic        tv;
    logic [31:0] tt;
    logic [31:0] exp_pc;
    logic        exp_pend;
    logic        exp_merr;
    logic [31:0] exp_maddr;
  } vec_t;

  vec_t vecs[$];
  int   n_vec;
  int   n_err;

  function automatic vec_t mk(input logic r, input logic s,
                              input logic bv, input logic [31:0] bt,
                              input logic jv, input logic [31:0] jt,
                              input logic tv, input logic [31:0] tt,
                              input logic [31:0] ep, input logic epd,
                              input logic em, input logic [31:0] ema);
    vec_t v;
    v.rst = r; v.stall = s; v.bv = bv; v.bt = bt; v.jv = jv; v.jt = jt;
    v.tv = tv; v.tt = tt; v.exp_pc = ep; v.exp_pend = epd;
    v.exp_merr = em; v.exp_maddr = ema;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s vec %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic drive1(input logic s, input logic jv, input logic [31:0] jt,
                        input logic tv, input logic [31:0] tt);
    bus1.stall = s; bus1.branch_taken = 1'b0; bus1.branch_target = '0;
    bus1.jump_valid = jv; bus1.jump_target = jt;
    bus1.trap_valid = tv; bus1.trap_target = tt;
  endtask

  task automatic check1(input int idx, input logic [31:0] ep, input logic epd,
                        input logic em, input logic [31:0] ema);
    n_vec++;
    chk("a1_pc",    idx, bus1.pc, ep);
    chk("a1_pend",  idx, {31'b0, bus1.redirect_pending}, {31'b0, epd});
    chk("a1_merr",  idx, {31'b0, bus1.misalign_err}, {31'b0, em});
    chk("a1_maddr", idx, bus1.misalign_addr, ema);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;

    //              rst stl bv bt            jv jt            tv tt             pc            pnd me maddr
    vecs.push_back(mk(1, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        32'h0,        0, 0, 32'h0));
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        32'h4,        0, 0, 32'h0));
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        32'h8,        0, 0, 32'h0));
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        32'hC,        0, 0, 32'h0));
    vecs.push_back(mk(0, 0, 1, 32'h300,      1, 32'h200,      0, 32'h0,        32'h200,      0, 0, 32'h0));
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        32'h204,      0, 0, 32'h0));
    vecs.push_back(mk(0, 1, 1, 32'h40,       0, 32'h0,        0, 32'h0,        32'h204,      1, 0, 32'h0));
    vecs.push_back(mk(0, 1, 0, 32'h0,        1, 32'h80,       0, 32'h0,        32'h204,      1, 0, 32'h0));
    vecs.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,        0, 32'h0,        32'h204,      1, 0, 32'h0));
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        32'h80,       0, 0, 32'h0));
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        32'h84,       0, 0, 32'h0));
    vecs.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,        1, 32'h100,      32'h84,       1, 0, 32'h0));
    vecs.push_back(mk(0, 1, 0, 32'h0,        1, 32'h500,      0, 32'h0,        32'h84,       1, 0, 32'h0));
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        32'h100,      0, 0, 32'h0));
    vecs.push_back(mk(0, 0, 0, 32'h0,        1, 32'h102,      0, 32'h0,        32'h104,      0, 1, 32'h102));
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        32'h108,      0, 0, 32'h102));
    vecs.push_back(mk(0, 0, 1, 32'h400,      1, 32'h10A,      0, 32'h0,        32'h400,      0, 1, 32'h10A));
    vecs.push_back(mk(0, 1, 1, 32'h302,      0, 32'h0,        0, 32'h0,        32'h400,      0, 1, 32'h302));
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        32'h404,      0, 0, 32'h302));
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h7FF,      32'h7FC,      0, 0, 32'h302));
    vecs.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,        1, 32'h900,      32'h7FC,      1, 0, 32'h302));
    vecs.push_back(mk(1, 1, 0, 32'h0,        1, 32'h600,      0, 32'h0,        32'h0,        0, 0, 32'h0));
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        32'h4,        0, 0, 32'h0));
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 0, 0, 32'h0));
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        32'h0,        0, 0, 32'h0));
    vecs.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,        0, 32'h0,        32'h0,        0, 0, 32'h0));
    vecs.push_back(mk(0, 1, 1, 32'h20,       0, 32'h0,        0, 32'h0,        32'h0,        1, 0, 32'h0));
    vecs.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,        1, 32'h40,       32'h0,        1, 0, 32'h0));
    vecs.push_back(mk(0, 0, 0, 32'h0,        1, 32'h60,       0, 32'h0,        32'h40,       0, 0, 32'h0));
    vecs.push_back(mk(0, 1, 1, 32'h20,       0, 32'h0,        0, 32'h0,        32'h40,       1, 0, 32'h0));
    vecs.push_back(mk(0, 0, 0, 32'h0,        1, 32'h88,       0, 32'h0,        32'h88,       0, 0, 32'h0));
    vecs.push_back(mk(0, 0, 1, 32'h30,       1, 32'h20,       1, 32'h10,       32'h10,       0, 0, 32'h0));
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        32'h14,       0, 0, 32'h0));
    vecs.push_back(mk(0, 1, 0, 32'h0,        1, 32'h50,       0, 32'h0,        32'h14,       1, 0, 32'h0));
    vecs.push_back(mk(0, 1, 0, 32'h0,        1, 32'h70,       0, 32'h0,        32'h14,       1, 0, 32'h0));
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        32'h70,       0, 0, 32'h0));

    rst1 = 1'b1;
    drive1(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);

    for (int i = 0; i < vecs.size(); i++) begin
      rst                = vecs[i].rst;
      bus0.stall         = vecs[i].stall;
      bus0.branch_taken  = vecs[i].bv;
      bus0.branch_target = vecs[i].bt;
      bus0.jump_valid    = vecs[i].jv;
      bus0.jump_target   = vecs[i].jt;
      bus0.trap_valid    = vecs[i].tv;
      bus0.trap_target   = vecs[i].tt;
      @(posedge clk);
      #1;
      n_vec++;
      chk("pc",        i, bus0.pc, vecs[i].exp_pc);
      chk("pc_plus_4", i, bus0.pc_plus_4, vecs[i].exp_pc + 32'd4);
      chk("pending",   i, {31'b0, bus0.redirect_pending}, {31'b0, vecs[i].exp_pend});
      chk("merr",      i, {31'b0, bus0.misalign_err}, {31'b0, vecs[i].exp_merr});
      chk("maddr",     i, bus0.misalign_addr, vecs[i].exp_maddr);
    end

    // Compressed-capable build: halfword targets are legal, odd ones are not.
    rst1 = 1'b1;
    drive1(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    @(posedge clk); #1;
    check1(100, 32'h1000, 1'b0, 1'b0, 32'h0);
    rst1 = 1'b0;
    drive1(1'b0, 1'b1, 32'h102, 1'b0, 32'h0);
    @(posedge clk); #1;
    check1(101, 32'h102, 1'b0, 1'b0, 32'h0);
    drive1(1'b0, 1'b1, 32'h103, 1'b0, 32'h0);
    @(posedge clk); #1;
    check1(102, 32'h106, 1'b0, 1'b1, 32'h103);
    drive1(1'b0, 1'b0, 32'h0, 1'b1, 32'h203);
    @(posedge clk); #1;
    check1(103, 32'h202, 1'b0, 1'b0, 32'h103);
    drive1(1'b1, 1'b1, 32'h3FE, 1'b0, 32'h0);
    @(posedge clk); #1;
    check1(104, 32'h202, 1'b1, 1'b0, 32'h103);
    drive1(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    @(posedge clk); #1;
    check1(105, 32'h3FE, 1'b0, 1'b0, 32'h103);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Parametrised program-counter sequencer for the RV32IM core: owns the PC register and selects the next PC from sequential, branch, jump and trap sources by fixed priority. Generalises the single-cycle next-PC select with a configurable reset vector, instruction alignment, a fetch stall, a pending-redirect latch for redirects arriving during a stall, and misaligned-target detection. Sits between the branch/jump resolution logic, the trap unit and the instruction-memory address port.

## Interface
- PC_WIDTH, 32, width of all address signals
- RESET_VECTOR, 32'h0000_0000, PC value loaded by reset
- ALIGN_BITS, 2, number of low target bits that must be zero (2 = RV32I, 1 = compressed-capable)
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- stall  in  1  hold PC; fetch not accepted this cycle
- branch_taken  in  1  resolved conditional branch redirect, single-cycle pulse
- branch_target  in  PC_WIDTH  branch destination
- jump_valid  in  1  JAL/JALR redirect, single-cycle pulse
- jump_target  in  PC_WIDTH  jump destination (JALR LSB already cleared upstream)
- trap_valid  in  1  trap/exception redirect, single-cycle pulse
- trap_target  in  PC_WIDTH  trap vector
- pc  out  PC_WIDTH  current fetch address (registered)
- pc_plus_4  out  PC_WIDTH  pc + 4, combinational, wraps modulo 2^PC_WIDTH
- redirect_pending  out  1  a redirect is latched, waiting for stall to drop
- misalign_err  out  1  one-cycle pulse: branch/jump target violated alignment
- misalign_addr  out  PC_WIDTH  offending target, valid when misalign_err=1

## Operation
- Source priority, highest first: trap, jump, branch, sequential.
- Effective request each cycle = highest-priority asserted input; if redirect_pending=1 and the pending entry has priority ≥ the new request (or no new request), the pending entry wins.
- stall=0: pc <= winning target if any, else pc_plus_4; pending latch cleared.
- stall=1: pc holds. A new request is written into the pending latch (target + priority class) only if latch empty or new priority ≥ stored priority; lower-priority requests are discarded.
- Trap targets: low ALIGN_BITS forced to zero; never raise misalign_err.
- Branch/jump target with nonzero low ALIGN_BITS: request is dropped (neither applied nor latched), misalign_err=1 and misalign_addr=target next cycle; PC behaves as if that request were absent (lower-priority valid branch in the same cycle still applies). The trap unit is expected to follow with trap_valid.
- Alignment is checked on arrival only; the pending latch holds only aligned targets.
- Arithmetic: pc_plus_4 = pc + 4 truncated to PC_WIDTH; 32'hFFFF_FFFC + 4 = 0.

## Timing
- Reset (rst=1 at edge): pc=RESET_VECTOR, redirect_pending=0, misalign_err=0, misalign_addr=0. Reset overrides stall and every redirect in the same cycle; a latched redirect is discarded.
- Redirect latency: 1 cycle; request at edge N visible on pc after edge N (stall=0).
- Pending redirect applies on the first edge with stall=0; redirect_pending falls on that same edge.
- misalign_err registered: high for exactly the cycle after the offending request, regardless of stall.
- Simultaneous trap+jump+branch: trap applied; others discarded, no pending entry retained for them.
- No combinational path from inputs to pc or redirect_pending; pc_plus_4 depends on pc only.

## Test plan
- Reset release, no redirects, stall=0: pc sequence 0x0, 0x4, 0x8, 0xC; misalign_err stays 0.
- jump_valid with jump_target=0x200 and branch_taken with 0x300 in same cycle -> pc=0x200 next cycle, then 0x204.
- stall=1 for 3 cycles, branch_taken 0x40 in cycle 1, jump 0x80 in cycle 2 -> pc holds, redirect_pending=1 from cycle 2, pc=0x80 on first unstalled edge, redirect_pending=0.
- Stalled with pending trap 0x100, then jump 0x500 arrives -> latch keeps 0x100; on stall release pc=0x100.
- jump_target=0x102 (ALIGN_BITS=2) -> pc advances to pc+4, misalign_err=1 one cycle, misalign_addr=0x102; ALIGN_BITS=1 build: same target -> pc=0x102, no error.
- Stalled with pending redirect, rst=1 -> pc=RESET_VECTOR, redirect_pending=0; pc=0xFFFF_FFFC sequential -> wraps to 0x0.
